// File: rtl/hdmi_video_timing_gen.sv
// Raster timing source for the HDMI output path: pixel/line counters, visible-window
// decode and sync/display-enable outputs delayed to meet the compositor's pixel pipeline.
module hdmi_video_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter bit          H_POL      = 1'b1,
    parameter bit          V_POL      = 1'b1,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    output logic        active,
    output logic [10:0] x_coord,
    output logic [9:0]  y_coord,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out
);

    localparam int unsigned XW      = 11;
    localparam int unsigned YW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Parameter sets that do not fit the coordinate ports are rejected at elaboration.
    if (H_TOTAL > (2 ** XW)) begin : g_h_total_err
        $error("hdmi_video_timing_gen: H_TOTAL-1 does not fit in x_coord");
    end
    if (V_TOTAL > (2 ** YW)) begin : g_v_total_err
        $error("hdmi_video_timing_gen: V_TOTAL-1 does not fit in y_coord");
    end
    if (PIPE_DELAY > 15) begin : g_pipe_err
        $error("hdmi_video_timing_gen: PIPE_DELAY must be in 0..15");
    end
    if (H_TOTAL == 0 || V_TOTAL == 0) begin : g_zero_err
        $error("hdmi_video_timing_gen: empty raster");
    end

    // One extra bit so window ends equal to the total never alias to zero.
    typedef logic [XW:0] hcmp_t;
    typedef logic [YW:0] vcmp_t;

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam hcmp_t         H_ACT_C  = hcmp_t'(H_ACTIVE);
    localparam hcmp_t         HS_BEG_C = hcmp_t'(H_ACTIVE + H_FP);
    localparam hcmp_t         HS_END_C = hcmp_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam vcmp_t         V_ACT_C  = vcmp_t'(V_ACTIVE);
    localparam vcmp_t         VS_BEG_C = vcmp_t'(V_ACTIVE + V_FP);
    localparam vcmp_t         VS_END_C = vcmp_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_OFF   = ~H_POL;
    localparam logic          VS_OFF   = ~V_POL;

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;
    logic [XW-1:0] x_coord_q, x_coord_d;
    logic [YW-1:0] y_coord_q, y_coord_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    hcmp_t         h_ext;
    vcmp_t         v_ext;

    // Counters hold the next point to show; the output registers decode the current one.
    always_comb begin
        h_cnt_d       = h_cnt_q + 1'b1;
        v_cnt_d       = v_cnt_q;
        h_ext         = hcmp_t'(h_cnt_q);
        v_ext         = vcmp_t'(v_cnt_q);
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        x_coord_d     = h_cnt_q;
        y_coord_d     = v_cnt_q;
        active_d      = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        hsync_d       = ((h_ext >= HS_BEG_C) && (h_ext < HS_END_C)) ? H_POL : HS_OFF;
        vsync_d       = ((v_ext >= VS_BEG_C) && (v_ext < VS_END_C)) ? V_POL : VS_OFF;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_coord_q     <= '0;
            y_coord_q     <= '0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= HS_OFF;
            vsync_q       <= VS_OFF;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_coord_q     <= x_coord_d;
            y_coord_q     <= y_coord_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign x_coord     = x_coord_q;
    assign y_coord     = y_coord_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    // Alignment delay between the decode registers and the TMDS encoder.
    if (PIPE_DELAY == 0) begin : g_no_delay
        assign hsync_out = hsync_q;
        assign vsync_out = vsync_q;
        assign de_out    = active_q;
    end else begin : g_delay
        logic [PIPE_DELAY-1:0] hs_dly_q, hs_dly_d;
        logic [PIPE_DELAY-1:0] vs_dly_q, vs_dly_d;
        logic [PIPE_DELAY-1:0] de_dly_q, de_dly_d;

        always_comb begin
            hs_dly_d    = hs_dly_q;
            vs_dly_d    = vs_dly_q;
            de_dly_d    = de_dly_q;
            hs_dly_d[0] = hsync_q;
            vs_dly_d[0] = vsync_q;
            de_dly_d[0] = active_q;
            for (int i = 1; i < int'(PIPE_DELAY); i++) begin
                hs_dly_d[i] = hs_dly_q[i-1];
                vs_dly_d[i] = vs_dly_q[i-1];
                de_dly_d[i] = de_dly_q[i-1];
            end
        end

        always_ff @(posedge pixel_clk) begin
            if (rst) begin
                hs_dly_q <= {PIPE_DELAY{HS_OFF}};
                vs_dly_q <= {PIPE_DELAY{VS_OFF}};
                de_dly_q <= '0;
            end else begin
                hs_dly_q <= hs_dly_d;
                vs_dly_q <= vs_dly_d;
                de_dly_q <= de_dly_d;
            end
        end

        assign hsync_out = hs_dly_q[PIPE_DELAY-1];
        assign vsync_out = vs_dly_q[PIPE_DELAY-1];
        assign de_out    = de_dly_q[PIPE_DELAY-1];
    end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Bench for hdmi_video_timing_gen: four parameterisations share clock and reset; a
// closed-form raster model feeds a scoreboard, plus a reset vector table and timing probes.
module tb_hdmi_video_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        act;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
    } obs_t;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        bit hp, vp;
        int pd;
    } cfg_t;

    typedef struct {
        logic rst;
        obs_t exp;
    } vec_t;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] x_w  [NI];
    logic [9:0]  y_w  [NI];
    logic        act_w[NI];
    logic        ls_w [NI];
    logic        fs_w [NI];
    logic        hs_w [NI];
    logic        vs_w [NI];
    logic        de_w [NI];

    cfg_t cfg[NI];
    obs_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   t      = -1;
    int   cyc    = 0;

    always #5 clk = ~clk;

    // 720p, no delay: line timing and hsync position
    hdmi_video_timing_gen #(.PIPE_DELAY(0)) u_d0 (
        .pixel_clk(clk), .rst(rst), .active(act_w[0]), .x_coord(x_w[0]), .y_coord(y_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]), .hsync_out(hs_w[0]),
        .vsync_out(vs_w[0]), .de_out(de_w[0]));
    // 720p, default delay of 1
    hdmi_video_timing_gen u_d1 (
        .pixel_clk(clk), .rst(rst), .active(act_w[1]), .x_coord(x_w[1]), .y_coord(y_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]), .hsync_out(hs_w[1]),
        .vsync_out(vs_w[1]), .de_out(de_w[1]));
    // small raster 24x12, delay 3
    hdmi_video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
                            .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                            .PIPE_DELAY(3)) u_s3 (
        .pixel_clk(clk), .rst(rst), .active(act_w[2]), .x_coord(x_w[2]), .y_coord(y_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]), .hsync_out(hs_w[2]),
        .vsync_out(vs_w[2]), .de_out(de_w[2]));
    // small raster, negative syncs, no delay
    hdmi_video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
                            .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                            .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(0)) u_sn (
        .pixel_clk(clk), .rst(rst), .active(act_w[3]), .x_coord(x_w[3]), .y_coord(y_w[3]),
        .line_start(ls_w[3]), .frame_start(fs_w[3]), .hsync_out(hs_w[3]),
        .vsync_out(vs_w[3]), .de_out(de_w[3]));

    // Expected outputs after t non-reset edges since the last reset edge (t<0: in reset).
    function automatic obs_t model(input cfg_t c, input int tt);
        obs_t o;
        int ht, vt, p, q, hx, vy;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        o = '0;
        o.hs = ~c.hp;
        o.vs = ~c.vp;
        if (tt < 0) return o;
        p = tt % (ht * vt);
        o.x   = 11'(p % ht);
        o.y   = 10'(p / ht);
        o.act = ((p % ht) < c.ha) && ((p / ht) < c.va);
        o.ls  = (p % ht) == 0;
        o.fs  = (p == 0);
        if (tt >= c.pd) begin
            q  = (tt - c.pd) % (ht * vt);
            hx = q % ht;
            vy = q / ht;
            o.de = (hx < c.ha) && (vy < c.va);
            o.hs = (hx >= c.ha + c.hf && hx < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
            o.vs = (vy >= c.va + c.vf && vy < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
        end
        return o;
    endfunction

    function automatic obs_t dut(input int i);
        obs_t o;
        o = {x_w[i], y_w[i], act_w[i], ls_w[i], fs_w[i], hs_w[i], vs_w[i], de_w[i]};
        return o;
    endfunction

    task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b exp x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b",
                     name, cyc, got.x, got.y, got.act, got.ls, got.fs, got.hs, got.vs, got.de,
                     exp.x, exp.y, exp.act, exp.ls, exp.fs, exp.hs, exp.vs, exp.de);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock: drive rst, queue model expectations, sample after the edge, score.
    task automatic step(input logic r);
        obs_t e;
        rst = r;
        t = r ? -1 : t + 1;
        for (int i = 0; i < NI; i++) sb_q.push_back(model(cfg[i], t));
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            e = sb_q.pop_front();
            chk_obs($sformatf("sb_inst%0d", i), dut(i), e);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   ls_last, ls_period, act_run, act_max, hs_rise_x, hs_fall_x;
        int   fs_last, fs_period;
        logic hs_prev;
        bit   found;

        cfg[0] = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, 0};
        cfg[1] = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, 1};
        cfg[2] = '{16, 2, 2, 4, 8, 1, 2, 1, 1'b1, 1'b1, 3};
        cfg[3] = '{16, 2, 2, 4, 8, 1, 2, 1, 1'b0, 1'b0, 0};

        // Reset hold and release on the delay-1 720p instance
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, obs_t'(27'd0)};
        vecs[5] = '{1'b0, '{x: 11'd0, y: 10'd0, act: 1'b1, ls: 1'b1, fs: 1'b1,
                            hs: 1'b0, vs: 1'b0, de: 1'b0}};
        vecs[6] = '{1'b0, '{x: 11'd1, y: 10'd0, act: 1'b1, ls: 1'b0, fs: 1'b0,
                            hs: 1'b0, vs: 1'b0, de: 1'b1}};
        vecs[7] = '{1'b0, '{x: 11'd2, y: 10'd0, act: 1'b1, ls: 1'b0, fs: 1'b0,
                            hs: 1'b0, vs: 1'b0, de: 1'b1}};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rst);
            chk_obs($sformatf("vec%0d", i), dut(1), vecs[i].exp);
            if (i == 4) chk_int("neg_pol_reset_hs", int'(hs_w[3]), 1);
        end

        // Free run: two full 720p lines and many small frames
        ls_last = -1; ls_period = 0; act_run = 0; act_max = 0;
        hs_rise_x = -1; hs_fall_x = -1; fs_last = -1; fs_period = 0;
        hs_prev = hs_w[0];
        for (int n = 0; n < 3400; n++) begin
            step(1'b0);
            if (ls_w[0]) begin
                if (ls_last >= 0) ls_period = cyc - ls_last;
                ls_last = cyc;
            end
            act_run = act_w[0] ? act_run + 1 : 0;
            if (act_run > act_max) act_max = act_run;
            if (hs_w[0] && !hs_prev) hs_rise_x = int'(x_w[0]);
            if (!hs_w[0] && hs_prev) hs_fall_x = int'(x_w[0]);
            hs_prev = hs_w[0];
            if (fs_w[2]) begin
                if (fs_last >= 0) fs_period = cyc - fs_last;
                fs_last = cyc;
            end
        end
        chk_int("line_start_period", ls_period, 1650);
        chk_int("active_run_len", act_max, 1280);
        chk_int("hsync_rise_x", hs_rise_x, 1390);
        chk_int("hsync_fall_x", hs_fall_x, 1430);
        chk_int("small_frame_period", fs_period, 288);

        // Mid-line reset on the 720p delay-1 instance at x=700
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            if (x_w[1] == 11'd700 && act_w[1]) found = 1'b1;
            else step(1'b0);
        end
        chk_int("reach_x700", int'(found), 1);
        step(1'b1);
        chk_obs("midreset_hold", dut(1), obs_t'(27'd0));
        step(1'b0);
        chk_obs("midreset_restart", dut(1), '{x: 11'd0, y: 10'd0, act: 1'b1, ls: 1'b1,
                                             fs: 1'b1, hs: 1'b0, vs: 1'b0, de: 1'b0});

        for (int n = 0; n < 900; n++) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
